pipe_share_ctrl: RTL and testbench
==================================

// Module: pipe_share_ctrl
// PURPOSE
//  Shares the two-stage t1/t2/t3 -> ff2 pipeline between two requesters and sequences it.
//  A round-robin arbiter accepts one 3-bit vector per transaction.
//  The FSM holds the vector on t1..t3 for the pipeline's latency, then samples ff2.
//  The sampled bit is returned, tagged with the requester id.
//  Sits beside the pipeline top; owns its t1..t3 inputs and observes ff2.
// PARAMETERS
//  PIPE_LAT  2  register stages from t1..t3 to ff2; legal range 1..15
// PORTS
//  clk         in   1  single clock; all state updates on posedge
//  rst         in   1  synchronous, active-high reset
//  req0_valid  in   1  requester 0 has a vector
//  req0_vec    in   3  requester 0 vector {t3,t2,t1}
//  req0_ready  out  1  requester 0 accepted this cycle when valid&ready
//  req1_valid  in   1  requester 1 has a vector
//  req1_vec    in   3  requester 1 vector {t3,t2,t1}
//  req1_ready  out  1  requester 1 accepted this cycle when valid&ready
//  t1,t2,t3    out  1  drive pipeline inputs (registered)
//  pipe_rst    out  1  drives pipeline rst; equals rst (combinational passthrough)
//  ff2         in   1  pipeline result
//  rsp_valid   out  1  one-cycle pulse: rsp_id/rsp_data valid
//  rsp_id      out  1  requester that owns the response
//  rsp_data    out  1  ff2 sampled for that transaction
//  busy        out  1  high while state is RUN
// BEHAVIOUR
//  Reset values: state=IDLE, t1..t3=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, cnt=0, last=1.
//   With last=1, req0 wins the first tie.
//  States: IDLE, RUN.
//  IDLE:
//   - reqN_ready is combinational. At most one ready is high.
//   - Only one valid high -> that requester is ready.
//   - Both valid high -> the requester != last is ready.
//   - Neither valid high -> both ready low.
//   - On accept: latch vec into t1..t3, owner<=N, last<=N, cnt<=0, state->RUN.
//  RUN:
//   - Both ready low. t1..t3 held stable. cnt increments each cycle.
//   - At the edge where cnt==PIPE_LAT:
//     - rsp_data<=ff2, rsp_id<=owner, rsp_valid<=1.
//     - t1..t3<=0, state->IDLE.
//  Timing:
//   - Accept at edge E -> vector on t1..t3 from E.
//   - ff2 sampled at edge E+PIPE_LAT+1. rsp_valid is high for the cycle after that edge.
//   - A new accept is allowed in that same cycle; back-to-back issue every PIPE_LAT+2 cycles.
//  rsp_valid is a single-cycle pulse; it is never held and there is no back-pressure.
//   Requesters must capture it.
//  A requester may drop valid in IDLE before accept with no effect.
//   Vector changes after accept are ignored.
//  rst high mid-RUN:
//   - Abort at that edge; all registers go to reset values.
//   - No rsp_valid for the aborted transaction.
//   - pipe_rst clears the pipeline in the same cycle.
//  cnt width: 4 bits; PIPE_LAT outside 1..15 is illegal (elaboration-time check).
// TESTING
//  1. Reset, then req0_valid=1, vec=3'b101, PIPE_LAT=2:
//     req0_ready=1 in cycle 0; t3,t2,t1=1,0,1 from edge 0; rsp_valid at cycle 4, rsp_id=0, rsp_data=ff2 model.
//  2. Both valid from reset, vectors 3'b011/3'b110, held high:
//     grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; issue every 4 cycles.
//  3. Only req1_valid, repeated 3 transactions:
//     req1 granted each time (no forced alternation); rsp_id=1 for all three.
//  4. rst asserted 1 cycle into RUN:
//     no rsp_valid; state IDLE, t1..t3=0, pipe_rst=1 that cycle; the next request is accepted normally.
//  5. req0_vec changed during RUN:
//     t1..t3 unchanged until return to IDLE; rsp_data reflects the original vector.
//  6. PIPE_LAT=1 build:
//     accept at edge E -> rsp_valid high in cycle E+3; back-to-back issue period 3 cycles.

Source files
------------

// File: rtl/pipe_share_ctrl.sv
// Two-requester front end for the t1/t2/t3 -> ff2 pipeline: round-robin accept,
// hold the vector for the pipeline latency, then return the sampled ff2 tagged with the owner.
module pipe_share_ctrl #(
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_vec,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_vec,
  output logic       req1_ready,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       pipe_rst,
  input  logic       ff2,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_data,
  output logic       busy
);

  generate
    if (PIPE_LAT < 1 || PIPE_LAT > 15) begin : g_bad_lat
      $error("pipe_share_ctrl: PIPE_LAT must lie in 1..15");
    end
  endgenerate

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] LAT_C  = 4'(PIPE_LAT);

  logic [0:0] state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic       rsp_data_q, rsp_data_d;
  logic       gnt0_s, gnt1_s;

  // Arbitration: on a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0_s = last_q;
        gnt1_s = ~last_q;
      end else begin
        gnt0_s = req0_valid;
        gnt1_s = req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state logic for the issue/wait sequencer.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          vec_d   = gnt1_s ? req1_vec : req0_vec;
          owner_d = gnt1_s;
          last_d  = gnt1_s;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == LAT_C) begin
          rsp_data_d  = ff2;
          rsp_id_d    = owner_q;
          rsp_valid_d = 1'b1;
          vec_d       = 3'b000;
          cnt_d       = 4'd0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = 4'(cnt_q + 4'd1);
        end
      end
      default: begin
        vec_d   = 3'b000;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 3'b000;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign t1         = vec_q[0];
  assign t2         = vec_q[1];
  assign t3         = vec_q[2];
  assign pipe_rst   = rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Directed bench for pipe_share_ctrl: PIPE_LAT=2 instance plus a PIPE_LAT=1 instance,
// each fed by a small pipeline model computing ff2 = t1 & ~t2 after the latency.
module tb_pipe_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       a_v0 = 1'b0, a_v1 = 1'b0;
  logic [2:0] a_vec0 = 3'b000, a_vec1 = 3'b000;
  logic       a_r0, a_r1, a_t1, a_t2, a_t3, a_prst, a_ff2, a_rv, a_rid, a_rd, a_busy;
  logic       b_v0 = 1'b0, b_v1 = 1'b0;
  logic [2:0] b_vec0 = 3'b000, b_vec1 = 3'b000;
  logic       b_r0, b_r1, b_t1, b_t2, b_t3, b_prst, b_ff2, b_rv, b_rid, b_rd, b_busy;

  int total = 0;
  int bad   = 0;

  pipe_share_ctrl #(.PIPE_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_v0), .req0_vec(a_vec0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_vec(a_vec1), .req1_ready(a_r1),
    .t1(a_t1), .t2(a_t2), .t3(a_t3), .pipe_rst(a_prst), .ff2(a_ff2),
    .rsp_valid(a_rv), .rsp_id(a_rid), .rsp_data(a_rd), .busy(a_busy)
  );

  pipe_share_ctrl #(.PIPE_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_vec(b_vec0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_vec(b_vec1), .req1_ready(b_r1),
    .t1(b_t1), .t2(b_t2), .t3(b_t3), .pipe_rst(b_prst), .ff2(b_ff2),
    .rsp_valid(b_rv), .rsp_id(b_rid), .rsp_data(b_rd), .busy(b_busy)
  );

  // Pipeline models: two stages for dut_a, one for dut_b.
  logic pa1 = 1'b0, pa2 = 1'b0, pb1 = 1'b0;
  always @(posedge clk) begin
    if (a_prst) begin
      pa1 <= 1'b0;
      pa2 <= 1'b0;
    end else begin
      pa1 <= a_t1 & ~a_t2;
      pa2 <= pa1;
    end
    if (b_prst) pb1 <= 1'b0;
    else        pb1 <= b_t1 & ~b_t2;
  end
  assign a_ff2 = pa2;
  assign b_ff2 = pb1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_prst", {3'b000, a_prst}, 4'h1);
    chk("rst_busy", {3'b000, a_busy}, 4'h0);
    chk("rst_rv", {3'b000, a_rv}, 4'h0);
    chk("rst_rid_rd", {2'b00, a_rid, a_rd}, 4'h0);
    chk("rst_t", {1'b0, a_t3, a_t2, a_t1}, 4'h0);
    rst = 1'b0;
    #1;
    chk("rst_prst_off", {3'b000, a_prst}, 4'h0);
    chk("idle_no_ready", {2'b00, a_r1, a_r0}, 4'h0);

    // 1: single request, vec 101, latency 2
    a_v0 = 1'b1; a_vec0 = 3'b101;
    #1;
    chk("t1_ready", {2'b00, a_r1, a_r0}, 4'h1);
    tick();
    a_v0 = 1'b0;
    chk("t1_vec", {1'b0, a_t3, a_t2, a_t1}, 4'h5);
    chk("t1_busy", {3'b000, a_busy}, 4'h1);
    chk("t1_run_noready", {2'b00, a_r1, a_r0}, 4'h0);
    tick();
    chk("t1_rv_c2", {3'b000, a_rv}, 4'h0);
    tick();
    chk("t1_rv_c3", {3'b000, a_rv}, 4'h0);
    chk("t1_vec_hold", {1'b0, a_t3, a_t2, a_t1}, 4'h5);
    tick();
    chk("t1_rsp", {1'b0, a_rv, a_rid, a_rd}, 4'h5);
    chk("t1_idle", {a_busy, a_t3, a_t2, a_t1}, 4'h0);
    tick();
    chk("t1_pulse", {3'b000, a_rv}, 4'h0);

    // 2: both valid, alternation 0,1,0,1 every 4 cycles (f(011)=f(110)=0)
    a_vec0 = 3'b011; a_vec1 = 3'b110;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_v0 = 1'b1; a_v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_ready", {2'b00, a_r1, a_r0}, (k % 2 == 0) ? 4'h1 : 4'h2);
      tick();
      chk("t2_vec", {1'b0, a_t3, a_t2, a_t1}, (k % 2 == 0) ? 4'h3 : 4'h6);
      tick();
      tick();
      chk("t2_early", {3'b000, a_rv}, 4'h0);
      tick();
      chk("t2_rsp", {1'b0, a_rv, a_rid, a_rd}, (k % 2 == 0) ? 4'h4 : 4'h6);
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick();
    chk("t2_pulse", {3'b000, a_rv}, 4'h0);

    // 3: only req1, three transactions; f(001)=1, f(100)=0, f(011)=0
    a_v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_vec1 = (k == 0) ? 3'b001 : ((k == 1) ? 3'b100 : 3'b011);
      #1;
      chk("t3_ready", {2'b00, a_r1, a_r0}, 4'h2);
      tick();
      tick();
      tick();
      tick();
      chk("t3_rsp", {1'b0, a_rv, a_rid, a_rd}, (k == 0) ? 4'h7 : 4'h6);
    end
    a_v1 = 1'b0;
    tick();

    // 4: reset one cycle into RUN
    a_v0 = 1'b1; a_vec0 = 3'b001;
    #1;
    chk("t4_ready", {2'b00, a_r1, a_r0}, 4'h1);
    tick();
    a_v0 = 1'b0;
    chk("t4_busy", {3'b000, a_busy}, 4'h1);
    rst = 1'b1;
    #1;
    chk("t4_prst", {3'b000, a_prst}, 4'h1);
    tick();
    rst = 1'b0;
    chk("t4_abort", {a_busy, a_t3, a_t2, a_t1}, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_norsp", {3'b000, a_rv}, 4'h0);
      tick();
    end
    a_v0 = 1'b1; a_v1 = 1'b1; a_vec0 = 3'b001; a_vec1 = 3'b100;
    #1;
    chk("t4_tie_after_rst", {2'b00, a_r1, a_r0}, 4'h1);
    tick();
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_rsp", {1'b0, a_rv, a_rid, a_rd}, 4'h5);
    tick();

    // 5: vector change during RUN is ignored
    a_v0 = 1'b1; a_vec0 = 3'b001;
    #1;
    tick();
    a_v0 = 1'b0; a_vec0 = 3'b110;
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold", {1'b0, a_t3, a_t2, a_t1}, 4'h1);
      tick();
    end
    chk("t5_rsp", {1'b0, a_rv, a_rid, a_rd}, 4'h5);
    tick();

    // 6: PIPE_LAT=1 instance, both valid: period 3, f(001)=1, f(010)=0
    b_vec0 = 3'b001; b_vec1 = 3'b010;
    b_v0 = 1'b1; b_v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_ready", {2'b00, b_r1, b_r0}, (k % 2 == 0) ? 4'h1 : 4'h2);
      tick();
      chk("t6_busy", {3'b000, b_busy}, 4'h1);
      tick();
      chk("t6_early", {3'b000, b_rv}, 4'h0);
      tick();
      chk("t6_rsp", {1'b0, b_rv, b_rid, b_rd}, (k % 2 == 0) ? 4'h5 : 4'h6);
    end
    b_v0 = 1'b0; b_v1 = 1'b0;
    tick();
    chk("t6_pulse", {3'b000, b_rv}, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
